boot_uart_ctrl: RTL and testbench
=================================

Name: boot_uart_ctrl

Overview:
- Bootloader command sequencer between the bootloader UART byte interface (rx/tx) and the SoC memories.
- Assembles 32-bit command headers from received bytes, then either streams received words into IMEM or streams DMEM words back out over UART.
- Holds the CPU in reset while IMEM is being written.
- Shares the DMEM read port with the CPU through a request/grant handshake.

Parameters:
- ADDR_WIDTH, 11, word-address width of IMEM/DMEM; addresses wrap modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 32, memory word width; only 32 is supported.
- TIMEOUT_CYCLES, 500000, idle cycles after which a partially received header or write payload is abandoned.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- rx_data  input  8  received UART byte
- rx_valid  input  1  one-cycle strobe, rx_data valid
- tx_data  output  8  byte to transmit
- tx_valid  output  1  tx_data valid; held until accepted
- tx_ready  input  1  UART transmitter can accept a byte
- imem_we  output  1  IMEM write strobe, one cycle
- imem_addr  output  ADDR_WIDTH  IMEM word address
- imem_wdata  output  32  IMEM write data
- dmem_req  output  1  DMEM read request
- dmem_gnt  input  1  DMEM read granted this cycle
- dmem_addr  output  ADDR_WIDTH  DMEM word address
- dmem_rdata  input  32  DMEM read data, valid the cycle after the grant
- cpu_hold  output  1  holds the CPU core in reset
- busy  output  1  high in any state other than IDLE
- err_timeout  output  1  one-cycle pulse when a command is aborted by timeout

Behaviour:
- Reset: all outputs 0; FSM goes to IDLE; byte counter, word counter and timeout counter cleared.
- Reset mid-command aborts the command immediately; no further imem_we or tx bytes are produced.
- Byte order: every word, header or payload, is little-endian (first byte is bits 7:0).
- Header fields: bit31 = 1 means write IMEM, 0 means read DMEM; bits 30:16 are the start word address, truncated to ADDR_WIDTH; bits 15:0 are ndata.
- IDLE / HDR: count 4 rx_valid bytes. The cycle after the 4th byte, decode the header:
  - ndata = 0: return to IDLE, no side effects.
  - Write command: go to WR_COLLECT and assert cpu_hold.
  - Read command: go to RD_REQ.
- WR_COLLECT: collect 4 bytes. On the cycle after the 4th byte, go to WR_COMMIT.
- WR_COMMIT: drive imem_we=1 for exactly one cycle with imem_addr = start + i and imem_wdata = the assembled word, then increment i.
  - If i reaches ndata: go to IDLE; cpu_hold deasserts the same cycle busy drops.
  - Otherwise: return to WR_COLLECT.
  - A byte arriving in the WR_COMMIT cycle is accepted as byte 0 of the next word.
- RD_REQ: hold dmem_req=1 with dmem_addr = start + i until dmem_gnt=1; go to RD_WAIT.
- RD_WAIT: capture dmem_rdata into the shift register; go to RD_SEND.
- RD_SEND: present byte k (k = 0..3) on tx_data with tx_valid=1.
  - On tx_valid && tx_ready, advance k; byte k+1 may be presented the next cycle.
  - After byte 3 is accepted, increment i. If i = ndata go to IDLE, otherwise go to RD_REQ.
  - tx_data and tx_valid are stable while tx_ready=0.
- rx_valid bytes arriving during RD_* states are discarded. cpu_hold stays 0 during reads.
- Address arithmetic: start + i computed in ADDR_WIDTH bits; wraps from 2^ADDR_WIDTH-1 to 0.
- Timeout: counter clears on every rx_valid and only runs in HDR with a nonzero byte count and in WR_COLLECT. On reaching TIMEOUT_CYCLES:
  - pulse err_timeout;
  - discard the partial word or header;
  - go to IDLE and release cpu_hold.
  - Words already committed remain in IMEM.
- Simultaneous rx_valid and timeout expiry in the same cycle: the byte wins and the timeout counter clears.

Test Plan:
- Write header 0x80000002 followed by words 0x11223344 and 0xAABBCCDD -> two imem_we pulses: addr 0 / 0x11223344, then addr 1 / 0xAABBCCDD. cpu_hold is high from header decode until after the 2nd write.
- Read header 0x00050003 with dmem_gnt delayed 3 cycles per request and DMEM[5..7] = 0xDEADBEEF, 1, 2 -> tx byte sequence EF BE AD DE 01 00 00 00 02 00 00 00. cpu_hold stays 0.
- Read with tx_ready toggled every other cycle -> no byte dropped or duplicated; tx_data stable while stalled.
- Header 0x80000000 (ndata = 0) -> no imem_we; busy returns to 0 within 2 cycles of the 4th byte.
- Write header 0x87FF0002 (address 2047, ADDR_WIDTH = 11) -> writes land at addr 2047 then addr 0.
- Write header 0x80000004 with only 6 payload bytes, then idle for TIMEOUT_CYCLES (set to 100) -> one imem_we (addr 0), err_timeout pulse, cpu_hold=0, IDLE. A subsequent valid header 0x00000001 works normally.
- Assert rst_n=0 during RD_SEND -> tx_valid, busy and cpu_hold go to 0 immediately; after release, the next header decodes correctly.

Source files
------------

// File: rtl/boot_uart_ctrl.sv
// Bootloader command sequencer: assembles little-endian headers from UART bytes,
// then streams payload words into IMEM or streams DMEM words back over UART.
module boot_uart_ctrl #(
  parameter int ADDR_WIDTH     = 11,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  dmem_req,
  input  logic                  dmem_gnt,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  err_timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DECODE, S_WR_COLLECT, S_WR_COMMIT, S_RD_REQ, S_RD_WAIT, S_RD_SEND
  } state_t;

  state_t                r_state, w_next;
  logic [DATA_WIDTH-1:0] r_word;
  logic [1:0]            r_byte_cnt;
  logic [ADDR_WIDTH-1:0] r_start;
  logic [15:0]           r_ndata;
  logic [15:0]           r_idx;
  logic [TW-1:0]         r_tmo;
  logic                  r_err;

  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_last_word;
  logic                  w_tmo_run;
  logic                  w_tmo_hit;
  logic                  w_hdr_wr;
  logic [15:0]           w_hdr_ndata;

  assign w_addr      = r_start + r_idx[ADDR_WIDTH-1:0];
  assign w_last_word = (r_idx + 16'd1) == r_ndata;
  assign w_hdr_wr    = r_word[31];
  assign w_hdr_ndata = r_word[15:0];
  assign w_tmo_run   = (r_state == S_HDR) || (r_state == S_WR_COLLECT);
  // A byte in the expiry cycle wins: the hit is suppressed and the counter clears.
  assign w_tmo_hit   = w_tmo_run && !rx_valid && (r_tmo == TW'(TIMEOUT_CYCLES - 1));

  assign tx_data     = r_word[7:0];
  assign imem_addr   = w_addr;
  assign imem_wdata  = r_word;
  assign dmem_addr   = w_addr;
  assign err_timeout = r_err;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next   = r_state;
    busy     = (r_state != S_IDLE);
    cpu_hold = (r_state == S_WR_COLLECT) || (r_state == S_WR_COMMIT);
    imem_we  = (r_state == S_WR_COMMIT);
    dmem_req = (r_state == S_RD_REQ);
    tx_valid = (r_state == S_RD_SEND);
    case (r_state)
      S_IDLE:       if (rx_valid) w_next = S_HDR;
      S_HDR: begin
        if (w_tmo_hit)                          w_next = S_IDLE;
        else if (rx_valid && r_byte_cnt == 2'd3) w_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_hdr_ndata == 16'd0) w_next = S_IDLE;
        else if (w_hdr_wr)        w_next = S_WR_COLLECT;
        else                      w_next = S_RD_REQ;
      end
      S_WR_COLLECT: begin
        if (w_tmo_hit)                          w_next = S_IDLE;
        else if (rx_valid && r_byte_cnt == 2'd3) w_next = S_WR_COMMIT;
      end
      S_WR_COMMIT:  w_next = w_last_word ? S_IDLE : S_WR_COLLECT;
      S_RD_REQ:     if (dmem_gnt) w_next = S_RD_WAIT;
      S_RD_WAIT:    w_next = S_RD_SEND;
      S_RD_SEND: begin
        if (tx_ready && r_byte_cnt == 2'd3) w_next = w_last_word ? S_IDLE : S_RD_REQ;
      end
      default:      w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word     <= '0;
      r_byte_cnt <= '0;
      r_start    <= '0;
      r_ndata    <= '0;
      r_idx      <= '0;
      r_tmo      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_tmo_hit;
      if (rx_valid || !w_tmo_run || w_tmo_hit) r_tmo <= '0;
      else                                     r_tmo <= r_tmo + TW'(1);

      case (r_state)
        S_IDLE: begin
          if (rx_valid) begin
            r_word     <= {rx_data, r_word[DATA_WIDTH-1:8]};
            r_byte_cnt <= 2'd1;
          end
        end
        S_HDR, S_WR_COLLECT: begin
          if (w_tmo_hit) begin
            r_byte_cnt <= '0;
          end else if (rx_valid) begin
            r_word     <= {rx_data, r_word[DATA_WIDTH-1:8]};
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
        end
        S_DECODE: begin
          r_start    <= r_word[16 +: ADDR_WIDTH];
          r_ndata    <= w_hdr_ndata;
          r_idx      <= '0;
          r_byte_cnt <= '0;
          // A payload byte landing in the decode cycle is kept as byte 0 of word 0.
          if (rx_valid && w_hdr_wr && w_hdr_ndata != 16'd0) begin
            r_word     <= {rx_data, r_word[DATA_WIDTH-1:8]};
            r_byte_cnt <= 2'd1;
          end
        end
        S_WR_COMMIT: begin
          r_idx <= r_idx + 16'd1;
          if (rx_valid && !w_last_word) begin
            r_word     <= {rx_data, r_word[DATA_WIDTH-1:8]};
            r_byte_cnt <= 2'd1;
          end
        end
        S_RD_WAIT: begin
          r_word     <= dmem_rdata;
          r_byte_cnt <= '0;
        end
        S_RD_SEND: begin
          if (tx_ready) begin
            r_word     <= {8'd0, r_word[DATA_WIDTH-1:8]};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) r_idx <= r_idx + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_uart_ctrl.sv
// Randomized bench for boot_uart_ctrl: expected IMEM writes and UART byte streams
// are computed from the command rules with plain address/byte arithmetic.
module tb_boot_uart_ctrl;

  localparam int AW    = 11;
  localparam int DEPTH = 1 << AW;
  localparam int TMO   = 100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          dmem_req;
  logic          dmem_gnt = 1'b0;
  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_rdata = '0;
  logic          cpu_hold;
  logic          busy;
  logic          err_timeout;

  boot_uart_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_req(dmem_req), .dmem_gnt(dmem_gnt), .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata),
    .cpu_hold(cpu_hold), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] dmem [DEPTH];
  int          gnt_delay  = 0;
  int          ready_mode = 0;
  int          tmo_pulses = 0;
  int          hold_bad   = 0;
  int          got_wa[$], exp_wa[$];
  logic [31:0] got_wd[$], exp_wd[$];
  logic [7:0]  got_tx[$], exp_tx[$];
  logic [31:0] pay;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max);
    for (int k = 0; k < 4; k++) send_byte(8'(w >> (8 * k)), $urandom_range(gap_max, 0));
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (busy && c < budget) begin
      tick();
      c++;
    end
    check("idle_within_budget", 64'(busy), 64'(0));
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_wr_count"}, 64'(got_wa.size()), 64'(exp_wa.size()));
    for (int i = 0; i < got_wa.size() && i < exp_wa.size(); i++) begin
      check({tag, "_wr_addr"}, 64'(got_wa[i]), 64'(exp_wa[i]));
      check({tag, "_wr_data"}, 64'(got_wd[i]), 64'(exp_wd[i]));
    end
    got_wa.delete(); got_wd.delete(); exp_wa.delete(); exp_wd.delete();
  endtask

  task automatic compare_tx(input string tag);
    check({tag, "_tx_count"}, 64'(got_tx.size()), 64'(exp_tx.size()));
    for (int i = 0; i < got_tx.size() && i < exp_tx.size(); i++)
      check({tag, "_tx_byte"}, 64'(got_tx[i]), 64'(exp_tx[i]));
    got_tx.delete(); exp_tx.delete();
  endtask

  task automatic write_cmd(input string tag, input logic [14:0] start, input int n, input int gap);
    send_word({1'b1, start, 16'(n)}, gap);
    for (int i = 0; i < n; i++) begin
      pay = $urandom;
      exp_wa.push_back((int'(start) + i) % DEPTH);
      exp_wd.push_back(pay);
      send_word(pay, gap);
    end
    wait_idle(2000);
    check({tag, "_hold_released"}, 64'(cpu_hold), 64'(0));
    compare_writes(tag);
  endtask

  task automatic read_cmd(input string tag, input logic [14:0] start, input int n,
                          input int delay, input int mode);
    logic [31:0] w;
    gnt_delay  = delay;
    ready_mode = mode;
    for (int i = 0; i < n; i++) begin
      w = dmem[(int'(start) + i) % DEPTH];
      for (int k = 0; k < 4; k++) exp_tx.push_back(8'((w >> (8 * k)) & 32'hFF));
    end
    send_word({1'b0, start, 16'(n)}, 2);
    wait_idle(5000);
    ready_mode = 0;
    compare_tx(tag);
  endtask

  initial begin : ready_driver
    forever begin
      tick();
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = 1'($urandom_range(1, 0));
        2:       tx_ready = ~tx_ready;
        default: tx_ready = 1'b0;
      endcase
    end
  end

  initial begin : dmem_model
    int wcnt;
    int gaddr;
    wcnt  = 0;
    gaddr = 0;
    forever begin
      tick();
      if (!rst_n) begin
        dmem_gnt = 1'b0;
        wcnt     = 0;
      end else if (dmem_gnt) begin
        dmem_gnt   = 1'b0;
        dmem_rdata = dmem[gaddr];
        wcnt       = 0;
      end else if (dmem_req) begin
        if (wcnt >= gnt_delay) begin
          dmem_gnt = 1'b1;
          gaddr    = int'(dmem_addr);
        end else begin
          wcnt++;
        end
      end else begin
        dmem_rdata = $urandom;
      end
    end
  end

  initial begin : monitor
    logic       prev_stall;
    logic [7:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (imem_we) begin
          got_wa.push_back(int'(imem_addr));
          got_wd.push_back(imem_wdata);
          if (!cpu_hold) hold_bad++;
        end
        if (tx_valid && tx_ready) got_tx.push_back(tx_data);
        if (cpu_hold && (dmem_req || tx_valid)) hold_bad++;
        if (err_timeout) tmo_pulses++;
        if (prev_stall) begin
          check("tx_stall_valid", 64'(tx_valid), 64'(1));
          check("tx_stall_data", 64'(tx_data), 64'(prev_data));
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int c;
    for (int i = 0; i < DEPTH; i++) dmem[i] = $urandom;
    repeat (3) tick();
    check("rst_ctrl_outputs",
          64'({tx_valid, imem_we, dmem_req, cpu_hold, busy, err_timeout}), 64'(0));
    check("rst_data_outputs", 64'({tx_data, imem_addr, dmem_addr, imem_wdata}), 64'(0));
    rst_n = 1'b1;
    tick();

    // Directed write: two words at address 0, hold asserted from decode.
    send_word(32'h8000_0002, 0);
    tick();
    check("t1_hold_after_decode", 64'(cpu_hold), 64'(1));
    send_word(32'h1122_3344, 2);
    send_word(32'hAABB_CCDD, 2);
    exp_wa.push_back(0); exp_wd.push_back(32'h1122_3344);
    exp_wa.push_back(1); exp_wd.push_back(32'hAABB_CCDD);
    wait_idle(2000);
    check("t1_hold_released", 64'(cpu_hold), 64'(0));
    compare_writes("t1");

    // Directed read with a 3-cycle grant delay.
    dmem[5] = 32'hDEAD_BEEF;
    dmem[6] = 32'h0000_0001;
    dmem[7] = 32'h0000_0002;
    read_cmd("t2", 15'd5, 3, 3, 0);

    // Read with tx_ready toggling every cycle.
    read_cmd("t3", 15'd100, 3, 1, 2);

    // ndata = 0: no side effects, busy drops quickly.
    send_word(32'h8000_0000, 0);
    c = 0;
    while (busy && c < 5) begin
      tick();
      c++;
    end
    check("t4_busy_drop_le2", 64'(c <= 2), 64'(1));
    repeat (5) tick();
    compare_writes("t4");

    // Address wrap 2047 -> 0.
    write_cmd("t5", 15'h07FF, 2, 1);

    // Randomized writes and reads.
    for (int r = 0; r < 4; r++)
      write_cmd("rw", 15'($urandom), $urandom_range(4, 1), 3);
    for (int r = 0; r < 4; r++)
      read_cmd("rr", 15'($urandom), $urandom_range(3, 1), $urandom_range(4, 0), $urandom_range(2, 0));

    // Timeout partway through the second payload word.
    check("no_spurious_timeout", 64'(tmo_pulses), 64'(0));
    send_word(32'h8000_0004, 1);
    pay = $urandom;
    exp_wa.push_back(0); exp_wd.push_back(pay);
    send_word(pay, 1);
    send_byte(8'h5A, 1);
    send_byte(8'hA5, 1);
    repeat (TMO + 50) tick();
    compare_writes("t6");
    check("t6_timeout_pulses", 64'(tmo_pulses), 64'(1));
    check("t6_hold_busy", 64'({cpu_hold, busy}), 64'(0));
    read_cmd("t6_next", 15'd0, 1, 0, 0);

    // Reset while stalled in the transmit state.
    ready_mode = 3;
    gnt_delay  = 1;
    send_word({1'b0, 15'd10, 16'd4}, 1);
    c = 0;
    while (!tx_valid && c < 100) begin
      tick();
      c++;
    end
    check("t7_reached_send", 64'(tx_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    check("t7_reset_outputs", 64'({tx_valid, busy, cpu_hold}), 64'(0));
    ready_mode = 0;
    repeat (3) tick();
    got_tx.delete();
    rst_n = 1'b1;
    repeat (20) tick();
    check("t7_no_tx_after_reset", 64'(got_tx.size()), 64'(0));
    write_cmd("t7_next", 15'd3, 1, 1);

    check("cpu_hold_behaviour", 64'(hold_bad), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
